// File: rtl/serial_reader_multi_if.sv
// -----------------------------------------------------------------------------
// serial_reader_multi_if
//   Groups the request/handshake and device-facing signals of
//   serial_reader_multi.
//
//   Signals:
//     start        request one frame (taken only while the reader is idle)
//     auto_repeat  chain the next frame automatically at the end of the gap
//     data_in      serial data lines, one per channel (asynchronous)
//     latch        device load strobe
//     pulse        device shift clock
//     data_out     last completed frame, channel c at [c*BITS +: BITS]
//     valid        one-cycle strobe, data_out updated on the same edge
//     busy         reader is not idle
//
//   Modports:
//     master  the side that requests frames and drives the device data
//     slave   the reader itself
// -----------------------------------------------------------------------------
interface serial_reader_multi_if #(
  parameter int BITS     = 8,
  parameter int CHANNELS = 1
);
  logic                     start;
  logic                     auto_repeat;
  logic [CHANNELS-1:0]      data_in;
  logic                     latch;
  logic                     pulse;
  logic [CHANNELS*BITS-1:0] data_out;
  logic                     valid;
  logic                     busy;

  modport master (
    output start, auto_repeat, data_in,
    input  latch, pulse, data_out, valid, busy
  );

  modport slave (
    input  start, auto_repeat, data_in,
    output latch, pulse, data_out, valid, busy
  );
endinterface

// File: rtl/serial_reader_multi.sv
// -----------------------------------------------------------------------------
// serial_reader_multi
//   Drives the latch/pulse strobe sequence of parallel-in/serial-out devices
//   and shifts in BITS bits on CHANNELS data lines at once. Each finished
//   frame is presented as one registered word with a one-cycle valid strobe.
//
//   Frame timing (one tick = DIV clk cycles):
//     LATCH 2 ticks -> SETTLE 1 tick (sample first bit)
//     -> (PULSE_HI 1 tick, PULSE_LO 1 tick, sample next bit) x (BITS-1)
//     -> GAP GAP_TICKS ticks -> IDLE, or straight back to LATCH when
//        auto_repeat is high at the end of the gap.
//
//   Ports:
//     clk    system clock, all logic on the rising edge
//     reset  synchronous, active-high reset
//     bus    serial_reader_multi_if slave modport (start, auto_repeat,
//            data_in, latch, pulse, data_out, valid, busy)
// -----------------------------------------------------------------------------
module serial_reader_multi #(
  parameter int BITS      = 8,
  parameter int CHANNELS  = 1,
  parameter int DIV       = 16,
  parameter int GAP_TICKS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_reader_multi_if.slave bus
);

  localparam int CW       = $clog2(DIV);
  localparam int BW       = $clog2(BITS);
  localparam int PW       = (GAP_TICKS > 2) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] PAIR_LAST = BW'(BITS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_PULSE_HI,
    S_PULSE_LO,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0] r_tick_cnt;
  logic [PW-1:0] r_phase_cnt;   // ticks spent in LATCH or GAP
  logic [BW-1:0] r_pair_cnt;    // completed PULSE_HI/PULSE_LO pairs

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  // Only BITS-1 bits need storing: the last bit of a frame goes straight
  // from the synchroniser into data_out.
  logic [BITS-2:0] r_shift [CHANNELS];
  logic [BITS-1:0] w_word  [CHANNELS];
  logic [CHANNELS*BITS-1:0] w_frame_word;

  logic                     r_latch;
  logic                     r_pulse;
  logic                     r_valid;
  logic                     r_busy;
  logic [CHANNELS*BITS-1:0] r_data_out;

  logic w_tick;
  logic w_sample;
  logic w_frame_done;
  logic w_enter_latch;
  logic w_latch_next;
  logic w_pulse_next;
  logic w_busy_next;

  assign w_tick        = (r_tick_cnt == TICK_LAST);
  assign w_sample      = w_tick && ((r_state == S_SETTLE) || (r_state == S_PULSE_LO));
  assign w_frame_done  = w_tick && (r_state == S_PULSE_LO) && (r_pair_cnt == PAIR_LAST);
  assign w_enter_latch = (w_state_next == S_LATCH) && (r_state != S_LATCH);

  // Per-channel word as it would look after shifting in the current sample.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign w_word[gi] = {r_shift[gi], r_sync2[gi]};
    assign w_frame_word[gi*BITS +: BITS] = w_word[gi];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_LATCH;
        end
      end
      S_LATCH: begin
        if (w_tick && (r_phase_cnt == PW'(1))) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_tick) begin
          w_state_next = S_PULSE_HI;
        end
      end
      S_PULSE_HI: begin
        if (w_tick) begin
          w_state_next = S_PULSE_LO;
        end
      end
      S_PULSE_LO: begin
        if (w_tick) begin
          if (r_pair_cnt != PAIR_LAST) begin
            w_state_next = S_PULSE_HI;
          end else if (GAP_TICKS != 0) begin
            w_state_next = S_GAP;
          end else begin
            // No gap: the repeat decision is taken on the completion edge.
            w_state_next = bus.auto_repeat ? S_LATCH : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (w_tick && (r_phase_cnt == PW'(GAP_LAST))) begin
          w_state_next = bus.auto_repeat ? S_LATCH : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (from the next state, so the strobes are registered
  // and change on the same edge as the state)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_latch_next = (w_state_next == S_LATCH);
    w_pulse_next = (w_state_next == S_PULSE_HI);
    w_busy_next  = (w_state_next != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Tick generator and phase/pair counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_phase_cnt <= '0;
      r_pair_cnt  <= '0;
    end else begin
      if (w_enter_latch) begin
        r_tick_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
      end

      if (r_state != w_state_next) begin
        r_phase_cnt <= '0;
      end else if (w_tick) begin
        r_phase_cnt <= r_phase_cnt + PW'(1);
      end

      if (w_enter_latch) begin
        r_pair_cnt <= '0;
      end else if (w_tick && (r_state == S_PULSE_LO)) begin
        r_pair_cnt <= r_pair_cnt + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchronisers and shift registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_shift[c] <= '0;
      end
    end else begin
      r_sync1 <= bus.data_in;
      r_sync2 <= r_sync1;
      if (w_sample) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_shift[c] <= w_word[c][BITS-2:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_latch    <= 1'b0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_latch <= w_latch_next;
      r_pulse <= w_pulse_next;
      r_busy  <= w_busy_next;
      r_valid <= w_frame_done;
      if (w_frame_done) begin
        r_data_out <= w_frame_word;
      end
    end
  end

  assign bus.latch    = r_latch;
  assign bus.pulse    = r_pulse;
  assign bus.busy     = r_busy;
  assign bus.valid    = r_valid;
  assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_serial_reader_multi.sv
// -----------------------------------------------------------------------------
// tb_serial_reader_multi
//   Directed bench for serial_reader_multi. Two instances:
//     dut_a  BITS=8, CHANNELS=4, DIV=4, GAP_TICKS=10
//     dut_b  BITS=4, CHANNELS=1, DIV=4, GAP_TICKS=0 (auto-repeat)
//   A device model per instance reloads its word while latch is high and
//   advances one bit on every falling edge of pulse, MSB first.
// -----------------------------------------------------------------------------
module tb_serial_reader_multi;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_reader_multi_if #(.BITS(8), .CHANNELS(4)) bus_a ();
  serial_reader_multi_if #(.BITS(4), .CHANNELS(1)) bus_b ();

  serial_reader_multi #(.BITS(8), .CHANNELS(4), .DIV(4), .GAP_TICKS(10)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  serial_reader_multi #(.BITS(4), .CHANNELS(1), .DIV(4), .GAP_TICKS(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Device model and monitor for dut_a (sampled 2 time units after posedge)
  // ---------------------------------------------------------------------------
  logic [7:0]  dev_a [4];
  int          a_idx;
  int          a_latch_rises, a_latch_rise_cyc, a_latch_len, a_pulse_rises;
  int          a_overlap, a_valid_cnt, a_valid_cyc, a_busy_fall_cyc;
  logic [31:0] a_data;

  initial begin
    logic pl, pp, pb;
    pl = 1'b0; pp = 1'b0; pb = 1'b0;
    a_idx = 8;
    bus_a.data_in = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_a.latch) a_idx = 0;
      else if (pp && !bus_a.pulse) a_idx++;
      for (int c = 0; c < 4; c++)
        bus_a.data_in[c] = (a_idx < 8) ? dev_a[c][7-a_idx] : 1'b0;
      if (bus_a.latch && !pl) begin a_latch_rises++; a_latch_rise_cyc = cyc; end
      if (!bus_a.latch && pl) a_latch_len = cyc - a_latch_rise_cyc;
      if (bus_a.pulse && !pp) a_pulse_rises++;
      if (bus_a.latch && bus_a.pulse) a_overlap++;
      if (bus_a.valid) begin a_valid_cnt++; a_valid_cyc = cyc; a_data = bus_a.data_out; end
      if (!bus_a.busy && pb) a_busy_fall_cyc = cyc;
      pl = bus_a.latch; pp = bus_a.pulse; pb = bus_a.busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Device model and monitor for dut_b
  // ---------------------------------------------------------------------------
  logic [3:0] tab_b [4];
  logic [3:0] b_word;
  int         b_idx, b_frames, b_busy_low;
  int         b_e0 = -1;
  int         b_rise_q[$];
  int         b_valid_q[$];
  logic [3:0] b_data_q[$];

  initial begin
    logic bpl, bpp;
    bpl = 1'b0; bpp = 1'b0;
    b_idx = 4;
    b_word = '0;
    bus_b.data_in = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus_b.latch && !bpl) begin
        b_word = tab_b[b_frames % 4];
        b_frames++;
        b_rise_q.push_back(cyc);
      end
      if (bus_b.latch) b_idx = 0;
      else if (bpp && !bus_b.pulse) b_idx++;
      bus_b.data_in[0] = (b_idx < 4) ? b_word[3-b_idx] : 1'b0;
      if (bus_b.valid) begin b_valid_q.push_back(cyc); b_data_q.push_back(bus_b.data_out); end
      if (b_e0 >= 0 && cyc >= b_e0 && cyc < b_e0 + 180 && !bus_b.busy) b_busy_low++;
      bpl = bus_b.latch; bpp = bus_b.pulse;
    end
  end

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One full frame on dut_a; optionally fires extra start pulses while busy.
  task automatic frame_a(input string name, input logic [31:0] words,
                         input logic [31:0] exp, input bit extra_starts);
    int e0, v0, p0, r0, n;
    v0 = a_valid_cnt; p0 = a_pulse_rises; r0 = a_latch_rises;
    for (int c = 0; c < 4; c++) dev_a[c] = words[c*8 +: 8];
    bus_a.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    if (extra_starts) begin
      goto_cyc(e0 + 19); bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
      goto_cyc(e0 + 49); bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
      goto_cyc(e0 + 89); bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    end
    n = 0;
    while (bus_a.busy && n < 300) begin @(negedge clk); n++; end
    check_val({name, "_idle"},       bus_a.busy, 0);
    check_val({name, "_latch_at"},   a_latch_rise_cyc - e0, 0);
    check_val({name, "_latch_len"},  a_latch_len, 8);
    check_val({name, "_pulses"},     a_pulse_rises - p0, 7);
    check_val({name, "_valid_cnt"},  a_valid_cnt - v0, 1);
    check_val({name, "_valid_at"},   a_valid_cyc - e0, 68);
    check_val({name, "_data"},       a_data, exp);
    check_val({name, "_busy_fall"},  a_busy_fall_cyc - e0, 108);
    repeat (12) @(negedge clk);
    check_val({name, "_one_window"}, a_latch_rises - r0, 1);
    check_val({name, "_stay_idle"},  bus_a.busy, 0);
    $display("frame %s: e0=%0d data_out=%h valid@+%0d", name, e0, a_data, a_valid_cyc - e0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, v0, n;
    bus_a.start = 1'b0; bus_a.auto_repeat = 1'b0;
    bus_b.start = 1'b0; bus_b.auto_repeat = 1'b0;
    for (int c = 0; c < 4; c++) dev_a[c] = '0;
    tab_b[0] = 4'h9; tab_b[1] = 4'h6; tab_b[2] = 4'hF; tab_b[3] = 4'h3;

    // Reset held for 3 cycles: every output low
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_a_outs", {bus_a.latch, bus_a.pulse, bus_a.valid, bus_a.busy, bus_a.data_out}, 0);
      check_val("rst_b_outs", {bus_b.latch, bus_b.pulse, bus_b.valid, bus_b.busy, bus_b.data_out}, 0);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_val("idle_after_rst", {bus_a.busy, bus_a.latch}, 0);
    $display("reset: outputs checked for 3 cycles");

    // Single frame, then distinct per-channel words
    frame_a("single", 32'h960FC3A5, 32'h960FC3A5, 1'b0);
    frame_a("multi",  32'h3CFF8001, 32'h3CFF8001, 1'b0);

    // Starts during LATCH/pulse phases and during GAP are ignored
    frame_a("busy_start", 32'h44332211, 32'h44332211, 1'b1);

    // Reset in the third PULSE_HI discards the frame and clears data_out
    v0 = a_valid_cnt;
    for (int c = 0; c < 4; c++) dev_a[c] = 8'h5A;
    bus_a.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    goto_cyc(e0 + 29);
    check_val("mid_in_pulse_hi", bus_a.pulse, 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_latch", bus_a.latch, 0);
    check_val("mid_pulse", bus_a.pulse, 0);
    check_val("mid_valid", bus_a.valid, 0);
    check_val("mid_busy",  bus_a.busy, 0);
    check_val("mid_data",  bus_a.data_out, 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check_val("mid_no_valid",  a_valid_cnt - v0, 0);
    check_val("mid_still_idle", bus_a.busy, 0);
    check_val("mid_data_kept", bus_a.data_out, 0);
    $display("reset mid-frame at e0+30: frame discarded");
    frame_a("after_rst", 32'hBD4218E7, 32'hBD4218E7, 1'b0);

    // Auto-repeat with no gap on dut_b
    @(negedge clk);
    b_e0 = cyc + 1;
    bus_b.auto_repeat = 1'b1;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    goto_cyc(b_e0 + 150);
    bus_b.auto_repeat = 1'b0;
    n = 0;
    while (bus_b.busy && n < 200) begin @(negedge clk); n++; end
    check_val("auto_idle", bus_b.busy, 0);
    repeat (20) @(negedge clk);
    check_val("auto_stays_idle", bus_b.busy, 0);
    check_val("auto_latch_windows", b_rise_q.size(), 5);
    check_val("auto_valids", b_valid_q.size(), 5);
    for (int i = 0; i < b_rise_q.size() && i < 5; i++)
      check_val($sformatf("auto_latch_at_%0d", i), b_rise_q[i] - b_e0, 36 * i);
    for (int i = 0; i < b_valid_q.size() && i < 5; i++) begin
      check_val($sformatf("auto_valid_at_%0d", i), b_valid_q[i] - b_e0, 36 * (i + 1));
      check_val($sformatf("auto_data_%0d", i), b_data_q[i], tab_b[i % 4]);
      $display("auto frame %0d: valid@+%0d data_out=%h", i, b_valid_q[i] - b_e0, b_data_q[i]);
    end
    check_val("auto_busy_low", b_busy_low, 0);

    check_val("latch_pulse_overlap", a_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
